q_max_sequencer: RTL and testbench
==================================

Name: q_max_sequencer

Overview:
- Serial max/argmax engine for Q-learning action selection.
- On request, reads the N_ACT Q-values of one state from the Q-table RAM, one per cycle, and tracks a running maximum and its action index.
- Returns {max Q, best action} through a valid/ready handshake.
- Sits between the agent control FSM and the Q-table RAM. It is the time-multiplexed alternative to the fully parallel max tree, for designs where Q-values live in memory rather than in registers.

Parameters:
- N_ACT, 15, number of actions per state; legal range 2..16.
- DW, 16, Q-value width; values are unsigned.
- SW, 8, state index width.
- AW_ACT, 4, action field width; requires 2**AW_ACT >= N_ACT.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  request; sampled only in IDLE.
- state_i  in  SW  state index; captured when start is accepted.
- busy_o  out  1  high in every state except IDLE.
- rd_en_o  out  1  Q-table read strobe.
- rd_addr_o  out  SW+AW_ACT  read address = {state, action}.
- rd_data_i  in  DW  Q-value; valid exactly 1 cycle after rd_en_o.
- res_valid_o  out  1  result valid.
- res_ready_i  in  1  consumer accepts the result.
- max_o  out  DW  maximum Q-value.
- act_o  out  AW_ACT  index of the maximum.

Behaviour:
- Reset (async assert, release sync to clk): FSM goes to IDLE.
- Reset values: busy_o=0, rd_en_o=0, rd_addr_o=0, res_valid_o=0, max_o=0, act_o=0.
- Reset asserted mid-operation discards the operation. No result is produced and no further reads are issued.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - If start_i=1: latch state_i, clear rd_cnt and rsp_cnt, go to READ.
  - Otherwise stay in IDLE.
- READ:
  - Drive rd_en_o=1 and rd_addr_o={state_q, rd_cnt}; rd_cnt increments each cycle.
  - Issue exactly N_ACT reads, action 0..N_ACT-1, on consecutive cycles.
  - After the read with rd_cnt=N_ACT-1, go to DRAIN.
- Response capture, in any cycle where the previous cycle had rd_en_o=1:
  - rsp_cnt==0: max_q=rd_data_i, act_q=0.
  - Otherwise, if rd_data_i > max_q (strict): max_q=rd_data_i, act_q=rsp_cnt.
  - rsp_cnt increments on every capture.
- Tie rule: on equal values the lower action index wins, matching the >= left-preference of the parallel max tree.
- DRAIN: rd_en_o=0. Capture the last response, then go to DONE.
- DONE:
  - res_valid_o=1; max_o and act_o stay stable while res_valid_o=1.
  - When res_ready_i=1, go to IDLE next cycle and drop res_valid_o.
  - If res_ready_i=0, hold DONE indefinitely.
- Latency, taking start acceptance as the IDLE cycle c:
  - Reads are issued in cycles c+1 .. c+N_ACT.
  - res_valid_o rises in cycle c+N_ACT+2 (c+17 for N_ACT=15).
- Throughput: one request per N_ACT+3 cycles minimum, including the IDLE acceptance cycle.
- start_i while busy_o=1 is ignored, not queued. A start presented in the same cycle as the res_ready_i handshake is ignored.
- The address never exceeds {state_q, N_ACT-1}. Action index N_ACT..15 is never read.
- Unsigned comparison throughout. 16'hFFFF is a legal maximum and must not wrap.

Decomposition:
- Package q_pkg holds the shared constants N_ACT, DW, SW, AW_ACT, shared with the Q-table and the parallel max tree.
- Package q_pkg holds the FSM state enum for IDLE, READ, DRAIN, DONE.
- One natural sub-module: q_max_acc. It contains the running max/argmax register pair with first/update inputs, about 40 lines.
- FSM and counters stay in the top module.

Test Plan:
- Monotonic values: state=3, RAM[3][a]=a*10 -> reads at addresses 0x30..0x3E on 15 consecutive cycles; res_valid at c+17; max_o=140, act_o=14.
- Ties: state=0, all Q=0x0100 except a5=a9=0x0FFF -> max_o=0x0FFF, act_o=5 (lower index wins).
- Extreme values: a0=0xFFFF, others 0 -> max_o=0xFFFF, act_o=0; a14=0xFFFF, a0=0xFFFE -> act_o=14.
- Backpressure: hold res_ready_i=0 for 10 cycles, pulse start_i during the stall -> outputs stable, no new rd_en_o; on ready=1, IDLE next cycle; a new start then begins reads one cycle later.
- Async reset: assert rst_n=0 during the 7th read -> busy_o, rd_en_o and res_valid_o drop immediately; after release no reads occur and no result is produced until a new start.
- Back-to-back: two requests for states 1 and 2 with res_ready_i tied high -> second read burst starts N_ACT+3=18 cycles after the first; both results correct.

Source files
------------

// File: rtl/q_pkg.sv
// ============================================================================
//  Module      : q_pkg
//  Description : Shared Q-learning constants and sequencer FSM state type.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package q_pkg;

  // Number of actions per state (2..16).
  localparam int N_ACT  = 15;
  // Q-value width, unsigned.
  localparam int DW     = 16;
  // State index width.
  localparam int SW     = 8;
  // Action field width; 2**AW_ACT must cover N_ACT.
  localparam int AW_ACT = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_t;

endpackage

`default_nettype wire

// File: rtl/q_max_sequencer_if.sv
// ============================================================================
//  Module      : q_max_sequencer_if
//  Description : Request, Q-table read port and result handshake bundle.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface q_max_sequencer_if;
  import q_pkg::*;

  logic                 start_i;
  logic [SW-1:0]        state_i;
  logic                 busy_o;
  logic                 rd_en_o;
  logic [SW+AW_ACT-1:0] rd_addr_o;
  logic [DW-1:0]        rd_data_i;
  logic                 res_valid_o;
  logic                 res_ready_i;
  logic [DW-1:0]        max_o;
  logic [AW_ACT-1:0]    act_o;

  // Sequencer side.
  modport master (
    input  start_i, state_i, rd_data_i, res_ready_i,
    output busy_o, rd_en_o, rd_addr_o, res_valid_o, max_o, act_o
  );

  // Agent control / Q-table side.
  modport slave (
    output start_i, state_i, rd_data_i, res_ready_i,
    input  busy_o, rd_en_o, rd_addr_o, res_valid_o, max_o, act_o
  );

endinterface

`default_nettype wire

// File: rtl/q_max_acc.sv
// ============================================================================
//  Module      : q_max_acc
//  Description : Running max / argmax register pair. 'first' loads the
//                value unconditionally; later updates replace the max only
//                on a strictly greater value so ties keep the lower index.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_max_acc
  import q_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              first,
  input  logic              update,
  input  logic [DW-1:0]     data,
  input  logic [AW_ACT-1:0] idx,
  output logic [DW-1:0]     max_q,
  output logic [AW_ACT-1:0] act_q
);

  // Load on the first response, then keep the strict unsigned maximum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      max_q <= '0;
      act_q <= '0;
    end else if (update) begin
      if (first) begin
        max_q <= data;
        act_q <= '0;
      end else if (data > max_q) begin
        max_q <= data;
        act_q <= idx;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/q_max_sequencer.sv
// ============================================================================
//  Module      : q_max_sequencer
//  Description : Serial max/argmax over the N_ACT Q-values of one state.
//                Issues one Q-table read per cycle, folds responses into
//                q_max_acc and presents {max, action} on a valid/ready port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module q_max_sequencer
  import q_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  q_max_sequencer_if.master  bus
);

  localparam logic [AW_ACT-1:0] LAST_ACT = AW_ACT'(N_ACT - 1);

  seq_state_t        fsm;
  seq_state_t        fsm_nxt;
  logic [SW-1:0]     state_q;
  logic [AW_ACT-1:0] rd_cnt;
  logic [AW_ACT-1:0] rsp_cnt;
  logic              rd_en_d;
  logic [DW-1:0]     max_q;
  logic [AW_ACT-1:0] act_q;

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) fsm <= IDLE;
    else        fsm <= fsm_nxt;
  end

  // Next-state decode; start is only looked at in IDLE.
  always_comb begin
    fsm_nxt = fsm;
    case (fsm)
      IDLE:    if (bus.start_i)        fsm_nxt = READ;
      READ:    if (rd_cnt == LAST_ACT) fsm_nxt = DRAIN;
      DRAIN:                           fsm_nxt = DONE;
      DONE:    if (bus.res_ready_i)    fsm_nxt = IDLE;
      default:                         fsm_nxt = IDLE;
    endcase
  end

  // Outputs are pure state decodes so reset clears them immediately.
  always_comb begin
    bus.busy_o      = (fsm != IDLE);
    bus.rd_en_o     = (fsm == READ);
    bus.res_valid_o = (fsm == DONE);
    bus.rd_addr_o   = (fsm == READ) ? {state_q, rd_cnt} : '0;
  end

  // Request latch and read/response counters; rd_en_d marks response cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= '0;
      rd_cnt  <= '0;
      rsp_cnt <= '0;
      rd_en_d <= 1'b0;
    end else begin
      rd_en_d <= (fsm == READ);
      if (fsm == IDLE && bus.start_i) begin
        state_q <= bus.state_i;
        rd_cnt  <= '0;
        rsp_cnt <= '0;
      end else begin
        if (fsm == READ) rd_cnt  <= rd_cnt + 1'b1;
        if (rd_en_d)     rsp_cnt <= rsp_cnt + 1'b1;
      end
    end
  end

  q_max_acc u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .first  (rsp_cnt == '0),
    .update (rd_en_d),
    .data   (bus.rd_data_i),
    .idx    (rsp_cnt),
    .max_q  (max_q),
    .act_q  (act_q)
  );

  assign bus.max_o = max_q;
  assign bus.act_o = act_q;

endmodule

`default_nettype wire

// File: tb/tb_q_max_sequencer.sv
// ============================================================================
//  Module      : tb_q_max_sequencer
//  Description : Self-checking bench for q_max_sequencer with a Q-table RAM
//                model and a reference max/argmax model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_q_max_sequencer;
  import q_pkg::*;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_err;

  logic [DW-1:0] mem [0:4095];
  int            rdq_cyc  [$];
  int            rdq_addr [$];

  q_max_sequencer_if bus ();

  q_max_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle counter, read log and one-cycle-latency Q-table RAM.
  always @(posedge clk) begin
    if (bus.rd_en_o) begin
      rdq_cyc.push_back(cyc);
      rdq_addr.push_back(int'(bus.rd_addr_o));
      bus.rd_data_i <= mem[bus.rd_addr_o];
    end
    cyc <= cyc + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: highest value over the state's row, first index wins ties.
  function automatic void ref_max(input int s, output int m, output int a);
    m = -1;
    a = 0;
    for (int k = 0; k < N_ACT; k++) begin
      if (int'(mem[s*16 + k]) > m) begin
        m = int'(mem[s*16 + k]);
        a = k;
      end
    end
  endfunction

  task automatic wait_valid(output int vc);
    int n;
    n = 0;
    while (!bus.res_valid_o && n < 60) begin
      step();
      n++;
    end
    chk("valid_timeout", bus.res_valid_o, 1'b1);
    vc = cyc;
  endtask

  // Pops one burst from the read log and checks cycle/address of every read.
  task automatic chk_burst(input int s, input int c);
    chk("burst_size_ok", rdq_cyc.size() >= N_ACT, 1'b1);
    for (int k = 0; k < N_ACT; k++) begin
      if (rdq_cyc.size() > 0) begin
        chk("read_cycle", rdq_cyc.pop_front(), c + 1 + k);
        chk("read_addr", rdq_addr.pop_front(), s*16 + k);
      end
    end
  endtask

  task automatic run_req(input int s);
    int c, vc, m, a;
    bus.start_i = 1'b1;
    bus.state_i = SW'(s);
    c = cyc;
    step();
    bus.start_i = 1'b0;
    wait_valid(vc);
    chk("latency", vc, c + N_ACT + 2);
    ref_max(s, m, a);
    chk("max", bus.max_o, m);
    chk("act", bus.act_o, a);
    bus.res_ready_i = 1'b1;
    step();
    bus.res_ready_i = 1'b0;
    chk("valid_drop", bus.res_valid_o, 1'b0);
    chk("idle_after", bus.busy_o, 1'b0);
    chk("no_extra_reads", rdq_cyc.size(), N_ACT);
    chk_burst(s, c);
    rdq_cyc.delete();
    rdq_addr.delete();
  endtask

  initial begin
    int c, m, a, m2, a2, s;
    logic [DW-1:0] hold_max;
    logic [AW_ACT-1:0] hold_act;
    int vcs[$];
    int vmax[$];
    int vact[$];
    logic saw_valid;

    n_checks = 0;
    n_err    = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    bus.start_i     = 1'b0;
    bus.state_i     = '0;
    bus.res_ready_i = 1'b0;
    bus.rd_data_i   = '0;
    for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);

    // Reset values.
    step();
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_rd_en", bus.rd_en_o, 1'b0);
    chk("rst_rd_addr", bus.rd_addr_o, 0);
    chk("rst_valid", bus.res_valid_o, 1'b0);
    chk("rst_max", bus.max_o, 0);
    chk("rst_act", bus.act_o, 0);
    step();
    rst_n = 1'b1;
    step();

    // Monotonic row.
    for (int k = 0; k < N_ACT; k++) mem[3*16 + k] = DW'(k * 10);
    run_req(3);

    // Ties: a5 and a9 share the maximum.
    for (int k = 0; k < N_ACT; k++) mem[0*16 + k] = 16'h0100;
    mem[5] = 16'h0FFF;
    mem[9] = 16'h0FFF;
    run_req(0);

    // Extremes.
    for (int k = 0; k < N_ACT; k++) mem[5*16 + k] = 16'h0000;
    mem[5*16] = 16'hFFFF;
    run_req(5);
    for (int k = 0; k < N_ACT; k++) mem[6*16 + k] = 16'h0000;
    mem[6*16]      = 16'hFFFE;
    mem[6*16 + 14] = 16'hFFFF;
    run_req(6);

    // Random rows, half of them drawn from a tiny range to force ties.
    for (int t = 0; t < 8; t++) begin
      s = $urandom_range(0, 255);
      if (t[0]) for (int k = 0; k < N_ACT; k++) mem[s*16 + k] = DW'($urandom_range(0, 3));
      run_req(s);
    end

    // Backpressure with a start pulse during the stall.
    s = 7;
    bus.start_i = 1'b1;
    bus.state_i = SW'(s);
    c = cyc;
    step();
    bus.start_i = 1'b0;
    wait_valid(m2);
    chk("bp_latency", m2, c + N_ACT + 2);
    ref_max(s, m, a);
    chk("bp_max", bus.max_o, m);
    chk("bp_act", bus.act_o, a);
    hold_max = bus.max_o;
    hold_act = bus.act_o;
    for (int i = 0; i < 10; i++) begin
      bus.start_i = (i == 3);
      bus.state_i = 8'h09;
      step();
      chk("bp_valid_hold", bus.res_valid_o, 1'b1);
      chk("bp_max_hold", bus.max_o, hold_max);
      chk("bp_act_hold", bus.act_o, hold_act);
    end
    bus.start_i = 1'b0;
    chk("bp_no_new_reads", rdq_cyc.size(), N_ACT);
    chk_burst(s, c);
    rdq_cyc.delete();
    rdq_addr.delete();
    bus.res_ready_i = 1'b1;
    step();
    bus.res_ready_i = 1'b0;
    chk("bp_idle", bus.busy_o, 1'b0);
    run_req(8);

    // Async reset during the 7th read.
    s = 4;
    bus.start_i = 1'b1;
    bus.state_i = SW'(s);
    step();
    bus.start_i = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("ar_rd_en_before", bus.rd_en_o, 1'b1);
    chk("ar_addr_before", bus.rd_addr_o, s*16 + 6);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_busy", bus.busy_o, 1'b0);
    chk("ar_rd_en", bus.rd_en_o, 1'b0);
    chk("ar_valid", bus.res_valid_o, 1'b0);
    rdq_cyc.delete();
    rdq_addr.delete();
    step();
    step();
    rst_n = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 25; i++) begin
      step();
      if (bus.res_valid_o || bus.busy_o) saw_valid = 1'b1;
    end
    chk("ar_no_result", saw_valid, 1'b0);
    chk("ar_no_reads", rdq_cyc.size(), 0);
    chk("ar_max_cleared", bus.max_o, 0);
    run_req(4);

    // Back-to-back with ready tied high and start held.
    bus.res_ready_i = 1'b1;
    bus.start_i = 1'b1;
    bus.state_i = 8'd1;
    c = cyc;
    step();
    bus.state_i = 8'd2;
    for (int i = 0; i < 45; i++) begin
      if (cyc == c + N_ACT + 4) bus.start_i = 1'b0;
      if (bus.res_valid_o) begin
        vcs.push_back(cyc);
        vmax.push_back(int'(bus.max_o));
        vact.push_back(int'(bus.act_o));
      end
      step();
    end
    bus.res_ready_i = 1'b0;
    bus.start_i = 1'b0;
    chk("b2b_results", vcs.size(), 2);
    while (vcs.size() < 2) begin
      vcs.push_back(-1);
      vmax.push_back(-1);
      vact.push_back(-1);
    end
    ref_max(1, m, a);
    ref_max(2, m2, a2);
    chk("b2b_valid1_cycle", vcs[0], c + N_ACT + 2);
    chk("b2b_valid2_cycle", vcs[1], c + 2*N_ACT + 5);
    chk("b2b_max1", vmax[0], m);
    chk("b2b_act1", vact[0], a);
    chk("b2b_max2", vmax[1], m2);
    chk("b2b_act2", vact[1], a2);
    chk("b2b_reads", rdq_cyc.size(), 2*N_ACT);
    chk_burst(1, c);
    chk_burst(2, c + N_ACT + 3);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
